// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encodings, default datapath width and a magnitude helper.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = 5;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_NOP6  = 3'd6,
        MDU_NOP7  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } mdu_state_e;

    // Two's-complement magnitude of a 32-bit value. 0x80000000 maps to itself,
    // which is the correct unsigned magnitude 2^31.
    function automatic logic [MDU_WIDTH-1:0] mdu_abs(input logic [MDU_WIDTH-1:0] v,
                                                     input logic                 neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the MDU datapath.
//   Multiply (is_div=0): {acc,low} holds the partial product with the
//   multiplier in low; add operand when low[0] is set, then shift right by one.
//   Divide   (is_div=1): acc is the partial remainder, low the dividend being
//   shifted out / quotient being shifted in; restoring subtract of operand.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] low,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] low_next
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;

    // Single add-shift or subtract-shift step; the carry/borrow lives in bit WIDTH.
    always_comb begin
        mul_sum   = {1'b0, acc} + (low[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        div_shift = {acc, low[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand};
        acc_next  = '0;
        low_next  = '0;
        if (is_div) begin
            // The partial remainder is always below the divisor, so a
            // non-negative difference never sets bit WIDTH.
            if (!div_diff[WIDTH]) begin
                acc_next = div_diff[WIDTH-1:0];
                low_next = {low[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = div_shift[WIDTH-1:0];
                low_next = {low[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = mul_sum[WIDTH:1];
            low_next = {mul_sum[0], low[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit for the EX stage. Operands are reduced to
// magnitudes on acceptance, WIDTH radix-2 steps run in RUN, and the sign
// fixup plus the HI/LO write happen in the single FINISH cycle.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e state_reg, state_next;
    mdu_op_e    op_e;

    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] low_reg;
    logic [WIDTH-1:0] opnd_reg;
    logic             is_div_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             div_zero_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             done_reg;

    logic             accept;
    logic             signed_req;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] low_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign op_e   = mdu_op_e'(op);
    assign accept = start && (state_reg == S_IDLE) && !op[2];
    assign busy   = (state_reg != S_IDLE);
    assign done   = done_reg;
    assign hi     = hi_reg;
    assign lo     = lo_reg;

    // Operand sign detection and magnitudes for the signed variants.
    always_comb begin
        signed_req = (op_e == MDU_MULT) || (op_e == MDU_DIV);
        a_neg      = signed_req && rs_val[WIDTH-1];
        b_neg      = signed_req && rt_val[WIDTH-1];
        a_mag      = mdu_abs(rs_val, a_neg);
        b_mag      = mdu_abs(rt_val, b_neg);
    end

    mdu_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .is_div   (is_div_reg),
        .acc      (acc_reg),
        .low      (low_reg),
        .operand  (opnd_reg),
        .acc_next (acc_next),
        .low_next (low_next)
    );

    // Sign correction applied when the result is committed in FINISH.
    always_comb begin
        prod_fix = {acc_reg, low_reg};
        if (neg_q_reg) begin
            prod_fix = ~prod_fix + 1'b1;
        end
        quot_fix = neg_q_reg ? (~low_reg + 1'b1) : low_reg;
        rem_fix  = neg_r_reg ? (~acc_reg + 1'b1) : acc_reg;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: WIDTH steps in RUN, then one FINISH cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = S_FINISH;
                end
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Datapath, counter and architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg      <= '0;
            acc_reg      <= '0;
            low_reg      <= '0;
            opnd_reg     <= '0;
            is_div_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        cnt_reg      <= '0;
                        acc_reg      <= '0;
                        is_div_reg   <= op[1];
                        neg_q_reg    <= a_neg ^ b_neg;
                        neg_r_reg    <= a_neg;
                        div_zero_reg <= op[1] && (rt_val == '0);
                        if (op[1]) begin
                            low_reg  <= a_mag;
                            opnd_reg <= b_mag;
                        end else begin
                            low_reg  <= b_mag;
                            opnd_reg <= a_mag;
                        end
                    end else if (start && (op_e == MDU_MTHI)) begin
                        hi_reg <= rs_val;
                    end else if (start && (op_e == MDU_MTLO)) begin
                        lo_reg <= rs_val;
                    end
                end
                S_RUN: begin
                    acc_reg <= acc_next;
                    low_reg <= low_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                S_FINISH: begin
                    done_reg <= 1'b1;
                    if (is_div_reg) begin
                        // With a zero divisor the remainder path has shifted the
                        // whole dividend magnitude into acc, so rem_fix restores
                        // the original dividend; only the quotient is forced.
                        hi_reg <= rem_fix;
                        lo_reg <= div_zero_reg ? '1 : quot_fix;
                    end else begin
                        hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fix[WIDTH-1:0];
                    end
                end
                default: begin
                    cnt_reg <= '0;
                end
            endcase
        end
    end

endmodule
